// File: rtl/dft_stream_sequencer.sv
// Frame sequencer around a streaming dft_top core: upstream framing, next/gap control, result framing.
// Optional next-to-next_out latency measurement is built when DFT_SEQ_LATCHK_EN is defined.
module dft_stream_sequencer #(
   parameter int LANES        = 32,
   parameter int WORD_W       = 64,
   parameter int FRAME_CYCLES = 32,
   parameter int MIN_GAP      = 190,
   parameter int CNT_W        = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_sof,
   input  logic [LANES*WORD_W-1:0]   in_data,
   output logic                      core_next,
   output logic [LANES*WORD_W-1:0]   core_x,
   input  logic                      core_next_out,
   input  logic [LANES*WORD_W-1:0]   core_y,
   output logic                      out_valid,
   output logic                      out_sof,
   output logic                      out_eof,
   output logic [LANES*WORD_W-1:0]   out_data,
   output logic                      underrun,
   output logic                      overlap,
   output logic [CNT_W-1:0]          lat_cycles
);

   localparam int DATA_W = LANES * WORD_W;
   localparam int IDX_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_TH   = CNT_W'(MIN_GAP - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NEXT = 2'd1,
      LOAD = 2'd2
   } state_t;

   state_t              state_r;
   logic [IDX_W-1:0]    load_idx_r;
   logic [CNT_W-1:0]    gap_cnt_r;
   logic [DATA_W-1:0]   skid_r;
   logic [DATA_W-1:0]   core_x_r;
   logic                live_r;
   logic                in_ready_r;
   logic                core_next_r;
   logic                underrun_r;

   logic [CNT_W-1:0]    gap_inc_s;
   logic                gap_ok_inc_s;
   logic [DATA_W-1:0]   live_x_s;

   logic                out_active_r;
   logic [IDX_W-1:0]    beat_r;
   logic                out_valid_r;
   logic                out_sof_r;
   logic                out_eof_r;
   logic [DATA_W-1:0]   out_data_r;
   logic                overlap_r;

   // Saturating gap increment and the live upstream pass-through vector.
   always_comb begin
      gap_inc_s = gap_cnt_r;
      live_x_s  = '0;
      if (gap_cnt_r != CNT_MAX) begin
         gap_inc_s = gap_cnt_r + CNT_W'(1);
      end else begin
         gap_inc_s = gap_cnt_r;
      end
      gap_ok_inc_s = (gap_inc_s >= GAP_TH);
      if (live_r && in_valid) begin
         live_x_s = in_data;
      end else begin
         live_x_s = '0;
      end
   end

   // Load cycles 1..FRAME_CYCLES-1 forward the accepted upstream vector in the same cycle.
   assign core_x    = live_r ? live_x_s : core_x_r;
   assign in_ready  = in_ready_r;
   assign core_next = core_next_r;
   assign underrun  = underrun_r;

   // Input FSM: frame start detection, core next pulse, frame load and gap enforcement.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         load_idx_r  <= '0;
         gap_cnt_r   <= CNT_MAX;
         skid_r      <= '0;
         core_x_r    <= '0;
         live_r      <= 1'b0;
         in_ready_r  <= 1'b0;
         core_next_r <= 1'b0;
         underrun_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready_r && in_sof) begin
                  skid_r      <= in_data;
                  state_r     <= NEXT;
                  core_next_r <= 1'b1;
                  gap_cnt_r   <= '0;
                  in_ready_r  <= 1'b0;
               end else begin
                  gap_cnt_r   <= gap_inc_s;
                  in_ready_r  <= gap_ok_inc_s;
               end
            end
            NEXT: begin
               state_r     <= LOAD;
               core_next_r <= 1'b0;
               load_idx_r  <= '0;
               core_x_r    <= skid_r;
               live_r      <= 1'b0;
               in_ready_r  <= 1'b0;
               gap_cnt_r   <= gap_inc_s;
            end
            LOAD: begin
               gap_cnt_r <= gap_inc_s;
               core_x_r  <= '0;
               if (live_r && !in_valid) begin
                  underrun_r <= 1'b1;
               end else begin
                  underrun_r <= underrun_r;
               end
               if (load_idx_r == LAST_IDX) begin
                  state_r    <= IDLE;
                  load_idx_r <= '0;
                  live_r     <= 1'b0;
                  in_ready_r <= gap_ok_inc_s;
               end else begin
                  load_idx_r <= load_idx_r + IDX_W'(1);
                  live_r     <= 1'b1;
                  in_ready_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               load_idx_r  <= '0;
               core_x_r    <= '0;
               live_r      <= 1'b0;
               in_ready_r  <= 1'b0;
               core_next_r <= 1'b0;
               gap_cnt_r   <= gap_inc_s;
            end
         endcase
      end
   end

   // Result framing: a next_out restart drops the coinciding beat so a truncated frame never shows eof.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_active_r <= 1'b0;
         beat_r       <= '0;
         out_valid_r  <= 1'b0;
         out_sof_r    <= 1'b0;
         out_eof_r    <= 1'b0;
         out_data_r   <= '0;
         overlap_r    <= 1'b0;
      end else if (core_next_out) begin
         if (out_active_r) begin
            overlap_r <= 1'b1;
         end else begin
            overlap_r <= overlap_r;
         end
         out_active_r <= 1'b1;
         beat_r       <= '0;
         out_valid_r  <= 1'b0;
         out_sof_r    <= 1'b0;
         out_eof_r    <= 1'b0;
      end else if (out_active_r) begin
         out_valid_r <= 1'b1;
         out_data_r  <= core_y;
         out_sof_r   <= (beat_r == '0);
         out_eof_r   <= (beat_r == LAST_IDX);
         if (beat_r == LAST_IDX) begin
            out_active_r <= 1'b0;
            beat_r       <= '0;
         end else begin
            beat_r       <= beat_r + IDX_W'(1);
         end
      end else begin
         out_valid_r <= 1'b0;
         out_sof_r   <= 1'b0;
         out_eof_r   <= 1'b0;
      end
   end

   assign out_valid = out_valid_r;
   assign out_sof   = out_sof_r;
   assign out_eof   = out_eof_r;
   assign out_data  = out_data_r;
   assign overlap   = overlap_r;

`ifdef DFT_SEQ_LATCHK_EN
   logic [CNT_W-1:0] lat_cnt_r;
   logic [CNT_W-1:0] lat_cycles_r;
   logic             lat_run_r;

   // Latency counter: the core_next cycle counts as 0, captured into lat_cycles at next_out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_cnt_r    <= '0;
         lat_cycles_r <= '0;
         lat_run_r    <= 1'b0;
      end else begin
         if (core_next_out) begin
            lat_cycles_r <= core_next_r ? '0 : lat_cnt_r;
         end else begin
            lat_cycles_r <= lat_cycles_r;
         end
         if (core_next_r && !core_next_out) begin
            lat_run_r <= 1'b1;
            lat_cnt_r <= CNT_W'(1);
         end else if (core_next_out) begin
            lat_run_r <= 1'b0;
         end else if (lat_run_r && (lat_cnt_r != CNT_MAX)) begin
            lat_cnt_r <= lat_cnt_r + CNT_W'(1);
         end else begin
            lat_cnt_r <= lat_cnt_r;
         end
      end
   end

   assign lat_cycles = lat_cycles_r;
`else
   assign lat_cycles = '0;
`endif

endmodule

// File: tb/tb_dft_stream_sequencer.sv
// Directed bench for dft_stream_sequencer; dft_top is modelled as a 6-cycle delay line on next and X.
module tb_dft_stream_sequencer;

   localparam int LANES   = 4;
   localparam int WORD_W  = 16;
   localparam int FC      = 4;
   localparam int MIN_GAP = 10;
   localparam int CNT_W   = 16;
   localparam int DW      = LANES * WORD_W;
`ifdef DFT_SEQ_LATCHK_EN
   localparam int EXP_LAT = 6;
`else
   localparam int EXP_LAT = 0;
`endif
   localparam logic [DW-1:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic            in_sof;
   logic [DW-1:0]   in_data;
   logic            core_next;
   logic [DW-1:0]   core_x;
   logic            core_next_out;
   logic [DW-1:0]   core_y;
   logic            out_valid;
   logic            out_sof;
   logic            out_eof;
   logic [DW-1:0]   out_data;
   logic            underrun;
   logic            overlap;
   logic [CNT_W-1:0] lat_cycles;

   logic            extra_nxo;
   logic [5:0]      nd;
   logic [DW-1:0]   xd [0:5];

   int              n_vec = 0;
   int              n_err = 0;
   int              cyc;
   int              last_nx;
   int              inj_at;
   logic            nx_seen;
   logic            hole_en;
   logic            rst_en;
   logic [DW-1:0]   rst_pre_exp;
   logic [DW:0]     txq [$];

   logic            nx_l  [0:63];
   logic            rdy_l [0:63];
   logic            ov_l  [0:63];
   logic            sof_l [0:63];
   logic            eof_l [0:63];
   logic            ur_l  [0:63];
   logic            ol_l  [0:63];
   logic [DW-1:0]   cx_l  [0:63];
   logic [DW-1:0]   od_l  [0:63];

   always #5 clk = ~clk;

   dft_stream_sequencer #(
      .LANES(LANES), .WORD_W(WORD_W), .FRAME_CYCLES(FC), .MIN_GAP(MIN_GAP), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
      .core_next(core_next), .core_x(core_x),
      .core_next_out(core_next_out), .core_y(core_y),
      .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .out_data(out_data),
      .underrun(underrun), .overlap(overlap), .lat_cycles(lat_cycles)
   );

   // Core model: next_out and Y follow next and X by six cycles.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         nd <= '0;
         for (int i = 0; i < 6; i++) xd[i] <= '0;
      end else begin
         nd    <= {nd[4:0], core_next};
         xd[0] <= core_x;
         for (int i = 1; i < 6; i++) xd[i] <= xd[i-1];
      end
   end
   assign core_next_out = nd[5] | extra_nxo;
   assign core_y        = xd[5];

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mkv(input int v);
      logic [DW-1:0] r;
      for (int k = 0; k < LANES; k++) r[k*WORD_W +: WORD_W] = WORD_W'(LANES * v + k);
      return r;
   endfunction

   task automatic push_frame(input int base);
      for (int k = 0; k < FC; k++) txq.push_back({(k == 0), mkv(base + k)});
   endtask

   task automatic new_scenario();
      cyc     = 0;
      nx_seen = 1'b0;
      last_nx = 0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_data   = '0;
      extra_nxo = 1'b0;
      txq.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_vec("reset_in_ready",   64'(in_ready),   64'd0);
      check_vec("reset_core_next",  64'(core_next),  64'd0);
      check_vec("reset_core_x",     64'(core_x),     64'd0);
      check_vec("reset_out_valid",  64'(out_valid),  64'd0);
      check_vec("reset_underrun",   64'(underrun),   64'd0);
      check_vec("reset_overlap",    64'(overlap),    64'd0);
      check_vec("reset_lat_cycles", 64'(lat_cycles), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      new_scenario();
   endtask

   task automatic count_ones(input int sel, input int lo, input int hi, output int c);
      c = 0;
      for (int i = lo; i <= hi; i++) c += (sel == 0) ? int'(nx_l[i]) : int'(eof_l[i]);
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         extra_nxo = (cyc == inj_at);
         if (txq.size() > 0 && !(hole_en && nx_seen && cyc == last_nx + 3)) begin
            in_valid = 1'b1;
            in_sof   = txq[0][DW];
            in_data  = txq[0][DW-1:0];
         end else begin
            in_valid = 1'b0;
            in_sof   = 1'b0;
            in_data  = JUNK;
         end
         if (rst_en && nx_seen && cyc == last_nx + 3) begin
            #1;
            check_vec("rst_pre_core_x", 64'(core_x), 64'(rst_pre_exp));
            reset = 1'b1;
            #1;
            check_vec("rst_async_in_ready",  64'(in_ready),   64'd0);
            check_vec("rst_async_core_next", 64'(core_next),  64'd0);
            check_vec("rst_async_core_x",    64'(core_x),     64'd0);
            check_vec("rst_async_out_valid", 64'(out_valid),  64'd0);
            check_vec("rst_async_overlap",   64'(overlap),    64'd0);
            check_vec("rst_async_lat",       64'(lat_cycles), 64'd0);
            reset    = 1'b0;
            rst_en   = 1'b0;
            nx_seen  = 1'b0;
            txq.delete();
            push_frame(12);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            in_data  = JUNK;
         end
         @(negedge clk);
         nx_l[cyc]  = core_next;
         rdy_l[cyc] = in_ready;
         cx_l[cyc]  = core_x;
         ov_l[cyc]  = out_valid;
         sof_l[cyc] = out_sof;
         eof_l[cyc] = out_eof;
         od_l[cyc]  = out_data;
         ur_l[cyc]  = underrun;
         ol_l[cyc]  = overlap;
         if (core_next) begin
            last_nx = cyc;
            nx_seen = 1'b1;
         end
         if (in_valid && in_ready) void'(txq.pop_front());
         cyc++;
      end
   endtask

   initial begin
      int c;
      reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; extra_nxo = 1'b0;
      inj_at = -1; hole_en = 1'b0; rst_en = 1'b0; rst_pre_exp = '0;
      new_scenario();

      // Single frame: core side timing, then result framing and latency.
      do_reset();
      push_frame(0);
      run_cycles(20);
      check_vec("t1_nx_c0", 64'(nx_l[0]), 64'd0);
      check_vec("t1_nx_c1", 64'(nx_l[1]), 64'd1);
      check_vec("t1_nx_c2", 64'(nx_l[2]), 64'd0);
      check_vec("t1_rdy_c0", 64'(rdy_l[0]), 64'd1);
      check_vec("t1_rdy_c1", 64'(rdy_l[1]), 64'd0);
      check_vec("t1_rdy_c2", 64'(rdy_l[2]), 64'd0);
      check_vec("t1_rdy_c3", 64'(rdy_l[3]), 64'd1);
      for (int k = 0; k < FC; k++) check_vec($sformatf("t1_core_x_%0d", k), 64'(cx_l[2+k]), 64'(mkv(k)));
      check_vec("t1_core_x_after", 64'(cx_l[6]), 64'd0);
      count_ones(0, 0, 19, c);
      check_vec("t1_nx_count", 64'(c), 64'd1);
      check_vec("t2_ov_before", 64'(ov_l[8]), 64'd0);
      for (int k = 0; k < FC; k++) begin
         check_vec($sformatf("t2_ov_%0d", k),   64'(ov_l[9+k]),  64'd1);
         check_vec($sformatf("t2_data_%0d", k), 64'(od_l[9+k]),  64'(mkv(k)));
         check_vec($sformatf("t2_sof_%0d", k),  64'(sof_l[9+k]), 64'(k == 0));
         check_vec($sformatf("t2_eof_%0d", k),  64'(eof_l[9+k]), 64'(k == FC-1));
      end
      check_vec("t2_ov_after", 64'(ov_l[13]), 64'd0);
      check_vec("t2_lat_cycles", 64'(lat_cycles), 64'(EXP_LAT));

      // Back-to-back frames: minimum gap between next pulses.
      do_reset();
      push_frame(0);
      push_frame(4);
      run_cycles(25);
      check_vec("t3_nx_first", 64'(nx_l[1]), 64'd1);
      check_vec("t3_nx_second", 64'(nx_l[11]), 64'd1);
      count_ones(0, 0, 24, c);
      check_vec("t3_nx_count", 64'(c), 64'd2);
      for (int t = 6; t <= 9; t++) check_vec($sformatf("t3_rdy_gap_c%0d", t), 64'(rdy_l[t]), 64'd0);
      check_vec("t3_rdy_c10", 64'(rdy_l[10]), 64'd1);
      check_vec("t3_core_x_b0", 64'(cx_l[12]), 64'(mkv(4)));
      check_vec("t3_core_x_b3", 64'(cx_l[15]), 64'(mkv(7)));

      // Upstream hole on load cycle 2.
      do_reset();
      hole_en = 1'b1;
      push_frame(0);
      run_cycles(25);
      hole_en = 1'b0;
      check_vec("t4_rdy_hole", 64'(rdy_l[4]), 64'd1);
      check_vec("t4_core_x_hole", 64'(cx_l[4]), 64'd0);
      check_vec("t4_core_x_c5", 64'(cx_l[5]), 64'(mkv(2)));
      check_vec("t4_core_x_end", 64'(cx_l[6]), 64'd0);
      check_vec("t4_rdy_end", 64'(rdy_l[6]), 64'd0);
      check_vec("t4_underrun_c4", 64'(ur_l[4]), 64'd0);
      check_vec("t4_underrun_c5", 64'(ur_l[5]), 64'd1);
      check_vec("t4_underrun_sticky", 64'(ur_l[24]), 64'd1);
      check_vec("t4_rdy_drop", 64'(rdy_l[10]), 64'd1);
      count_ones(0, 0, 24, c);
      check_vec("t4_nx_count", 64'(c), 64'd1);

      // Second next_out two cycles into a result frame.
      do_reset();
      inj_at = 9;
      push_frame(0);
      run_cycles(20);
      inj_at = -1;
      check_vec("t5_ov_c9", 64'(ov_l[9]), 64'd1);
      check_vec("t5_sof_c9", 64'(sof_l[9]), 64'd1);
      check_vec("t5_overlap_c9", 64'(ol_l[9]), 64'd0);
      check_vec("t5_ov_c10", 64'(ov_l[10]), 64'd0);
      check_vec("t5_overlap_c10", 64'(ol_l[10]), 64'd1);
      check_vec("t5_sof_new", 64'(sof_l[11]), 64'd1);
      check_vec("t5_data_new", 64'(od_l[11]), 64'(mkv(2)));
      count_ones(1, 8, 13, c);
      check_vec("t5_no_trunc_eof", 64'(c), 64'd0);
      check_vec("t5_eof_new", 64'(eof_l[14]), 64'd1);
      check_vec("t5_overlap_sticky", 64'(ol_l[19]), 64'd1);

      // Reset during load cycle 2, then an immediate new frame.
      new_scenario();
      rst_en = 1'b1;
      rst_pre_exp = mkv(10);
      push_frame(8);
      run_cycles(15);
      check_vec("t6_reset_applied", 64'(rst_en), 64'd0);
      check_vec("t6_rdy_after", 64'(rdy_l[5]), 64'd1);
      check_vec("t6_nx_after", 64'(nx_l[6]), 64'd1);
      check_vec("t6_core_x_new", 64'(cx_l[7]), 64'(mkv(12)));
      check_vec("t6_overlap_cleared", 64'(ol_l[5]), 64'd0);
      check_vec("t6_no_aborted_out", 64'(ov_l[9]), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
